spi_slave_burst_ctrl: RTL and testbench

SPI_SLAVE_BURST_CTRL -- requirements
Module: spi_slave_burst_ctrl

---
 rtl/spi_slave_burst_ctrl_if.sv | 27 ++
 rtl/spi_slave_burst_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_slave_burst_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_burst_ctrl_if.sv
// rtl/spi_slave_burst_ctrl_if.sv - SPI pins and memory-side strobes of the burst controller
// slave modport is the controller's view; master is the host/memory side.
interface spi_slave_burst_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              SCK;
  logic              CS;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W-1:0] Data_in;
  logic [DATA_W-1:0] Data_out;
  logic [ADDR_W-1:0] Addr;
  logic              WE;
  logic              RE;
  logic              Wrap;

  modport slave (
    input  SCK, CS, MOSI, Data_in,
    output MISO, Data_out, Addr, WE, RE, Wrap
  );

  modport master (
    output SCK, CS, MOSI, Data_in,
    input  MISO, Data_out, Addr, WE, RE, Wrap
  );
endinterface

// File: rtl/spi_slave_burst_ctrl.sv
// rtl/spi_slave_burst_ctrl.sv - SPI slave (CPOL=0, LSB first) bridging frames to memory read/write strobes
// Optional burst modes with address auto-increment are enabled by defining SPI_BURST_EN.
module spi_slave_burst_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_slave_burst_ctrl_if.slave bus
);
  localparam int MAX_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int CNT_W = $clog2(MAX_W + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MODE  = 3'd1,
    ADDR  = 3'd2,
    TURN  = 3'd3,
    RDATA = 3'd4,
    WDATA = 3'd5,
    DONE  = 3'd6
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] sync_vld_q, sync_vld_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   armed_q, armed_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             mode_q, mode_d;
  logic [ADDR_W-1:0]      addr_sh_q, addr_sh_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d;
  logic [DATA_W-1:0]      data_out_q, data_out_d;
  logic                   we_q, we_d;
  logic                   re_q, re_d;
  logic                   wrap_q, wrap_d;

  logic                   sck_s, cs_s, mosi_s, sck_rise;
  logic                   burst;
  logic [ADDR_W-1:0]      addr_inc;
  logic                   addr_wrap;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;

`ifdef SPI_BURST_EN
  assign burst     = mode_q[0];
  assign addr_inc  = addr_q + 1'b1;
  assign addr_wrap = &addr_q;
`else
  assign burst     = 1'b0;
  assign addr_inc  = addr_q;
  assign addr_wrap = 1'b0;
  logic unused_mode0;
  assign unused_mode0 = mode_q[0];
`endif

  // Frames are only accepted once CS has been seen high through a fully flushed
  // synchroniser, so a reset in the middle of a frame cannot resume that frame.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], bus.SCK};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.CS};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
    sync_vld_d  = {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
    sck_prev_d  = sck_s;
    armed_d     = armed_q | (cs_s & sync_vld_q[SYNC_STAGES-1]);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    addr_sh_d  = addr_sh_q;
    addr_d     = addr_q;
    shreg_d    = shreg_q;
    data_out_d = data_out_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    wrap_d     = 1'b0;

    if (cs_s) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (armed_q) begin
            state_d = MODE;
            cnt_d   = '0;
          end
        end
        MODE: begin
          if (sck_rise) begin
            mode_d = {mosi_s, mode_q[1]};
            if (cnt_q == CNT_W'(1)) begin
              cnt_d   = '0;
              state_d = ADDR;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ADDR: begin
          if (sck_rise) begin
            addr_sh_d = {mosi_s, addr_sh_q[ADDR_W-1:1]};
            if (cnt_q == CNT_W'(ADDR_W - 1)) begin
              cnt_d   = '0;
              addr_d  = addr_sh_d;
              state_d = mode_q[1] ? WDATA : TURN;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        TURN: begin
          // RE is held for the clk after the dummy rise; memory data is captured at its end.
          if (re_q) begin
            shreg_d = bus.Data_in;
            cnt_d   = '0;
            state_d = RDATA;
          end else if (sck_rise) begin
            re_d = 1'b1;
          end
        end
        RDATA: begin
          if (sck_rise) begin
            shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              cnt_d = '0;
              if (burst) begin
                addr_d  = addr_inc;
                wrap_d  = addr_wrap;
                state_d = TURN;
              end else begin
                state_d = DONE;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        WDATA: begin
          if (we_q && burst) begin
            addr_d = addr_inc;
            wrap_d = addr_wrap;
          end
          if (sck_rise) begin
            shreg_d = {mosi_s, shreg_q[DATA_W-1:1]};
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              cnt_d      = '0;
              data_out_d = shreg_d;
              we_d       = 1'b1;
              if (!burst) begin
                state_d = DONE;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sync_vld_q  <= '0;
      sck_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= '0;
      addr_sh_q   <= '0;
      addr_q      <= '0;
      shreg_q     <= '0;
      data_out_q  <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sync_vld_q  <= sync_vld_d;
      sck_prev_q  <= sck_prev_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      addr_sh_q   <= addr_sh_d;
      addr_q      <= addr_d;
      shreg_q     <= shreg_d;
      data_out_q  <= data_out_d;
      we_q        <= we_d;
      re_q        <= re_d;
      wrap_q      <= wrap_d;
    end
  end

  assign bus.MISO     = (state_q == RDATA) ? shreg_q[0] : 1'b0;
  assign bus.Data_out = data_out_q;
  assign bus.Addr     = addr_q;
  assign bus.WE       = we_q;
  assign bus.RE       = re_q;
  assign bus.Wrap     = wrap_q;
endmodule

// File: tb/tb_spi_slave_burst_ctrl.sv
// tb/tb_spi_slave_burst_ctrl.sv - directed self-checking bench for spi_slave_burst_ctrl
// Expectations follow the build: burst results when SPI_BURST_EN is defined, single-transfer results otherwise.
module tb_spi_slave_burst_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
`ifdef SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  spi_slave_burst_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  spi_slave_burst_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.Data_in = mem[bus.Addr];

  int we_cnt = 0;
  int re_cnt = 0;
  int wrap_cnt = 0;
  logic [ADDR_W-1:0] we_addr [64];
  logic [DATA_W-1:0] we_data [64];
  logic [ADDR_W-1:0] re_addr [64];

  always @(negedge clk) begin
    if (bus.WE === 1'b1) begin
      we_addr[we_cnt % 64] = bus.Addr;
      we_data[we_cnt % 64] = bus.Data_out;
      we_cnt = we_cnt + 1;
    end
    if (bus.RE === 1'b1) begin
      re_addr[re_cnt % 64] = bus.Addr;
      re_cnt = re_cnt + 1;
    end
    if (bus.Wrap === 1'b1) wrap_cnt = wrap_cnt + 1;
  end

  task automatic spi_bit(input logic mosi_v, output logic miso_v);
    bus.MOSI = mosi_v;
    repeat (4) @(negedge clk);
    miso_v = bus.MISO;
    bus.SCK = 1'b1;
    repeat (4) @(negedge clk);
    bus.SCK = 1'b0;
  endtask

  task automatic xfer(input logic [31:0] bits, input int n, output logic [31:0] rx);
    logic b;
    rx = '0;
    for (int i = 0; i < n; i++) begin
      spi_bit(bits[i], b);
      rx[i] = b;
    end
  endtask

  task automatic cs_start();
    @(negedge clk);
    bus.CS = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_end();
    bus.CS = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.SCK = 1'b0;
    bus.CS = 1'b1;
    bus.MOSI = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (bus.MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b expected 0", bus.MISO); end
    n_checks++; if (bus.Data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", bus.Data_out); end
    n_checks++; if (bus.Addr !== 5'h00) begin n_fail++; $display("FAIL reset_addr: got %h expected 00", bus.Addr); end
    n_checks++; if (bus.WE !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", bus.WE); end
    n_checks++; if (bus.RE !== 1'b0) begin n_fail++; $display("FAIL reset_re: got %b expected 0", bus.RE); end
    n_checks++; if (bus.Wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b expected 0", bus.Wrap); end
  endtask

  task automatic test_single_write();
    int we0, re0;
    logic [31:0] rx;
    we0 = we_cnt; re0 = re_cnt;
    cs_start();
    xfer({25'd0, 5'h0A, 2'b10}, 7, rx);
    xfer(32'hA5, 8, rx);
    xfer(32'h0F, 4, rx);
    cs_end();
    n_checks++; if (we_cnt - we0 !== 1) begin n_fail++; $display("FAIL swr_we_count: got %0d expected 1", we_cnt - we0); end
    n_checks++; if (we_addr[we0 % 64] !== 5'h0A) begin n_fail++; $display("FAIL swr_addr: got %h expected 0a", we_addr[we0 % 64]); end
    n_checks++; if (we_data[we0 % 64] !== 8'hA5) begin n_fail++; $display("FAIL swr_data: got %h expected a5", we_data[we0 % 64]); end
    n_checks++; if (re_cnt - re0 !== 0) begin n_fail++; $display("FAIL swr_re_count: got %0d expected 0", re_cnt - re0); end
  endtask

  task automatic test_single_read();
    int we0, re0;
    logic [31:0] rx;
    we0 = we_cnt; re0 = re_cnt;
    mem[3] = 8'h3C;
    cs_start();
    xfer({25'd0, 5'h03, 2'b00}, 7, rx);
    xfer(32'h0, 1, rx);
    xfer(32'h0, 8, rx);
    cs_end();
    n_checks++; if (re_cnt - re0 !== 1) begin n_fail++; $display("FAIL srd_re_count: got %0d expected 1", re_cnt - re0); end
    n_checks++; if (re_addr[re0 % 64] !== 5'h03) begin n_fail++; $display("FAIL srd_addr: got %h expected 03", re_addr[re0 % 64]); end
    n_checks++; if (rx[7:0] !== 8'h3C) begin n_fail++; $display("FAIL srd_miso_word: got %h expected 3c", rx[7:0]); end
    n_checks++; if (we_cnt - we0 !== 0) begin n_fail++; $display("FAIL srd_we_count: got %0d expected 0", we_cnt - we0); end
    n_checks++; if (bus.MISO !== 1'b0) begin n_fail++; $display("FAIL srd_miso_idle: got %b expected 0", bus.MISO); end
  endtask

  task automatic test_burst_write();
    int we0, wr0, exp_n;
    logic [31:0] rx;
    logic [ADDR_W-1:0] exp_a [3];
    logic [DATA_W-1:0] exp_d [3];
    exp_a[0] = 5'h1E; exp_a[1] = 5'h1F; exp_a[2] = 5'h00;
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    exp_n = BURST ? 3 : 1;
    we0 = we_cnt; wr0 = wrap_cnt;
    cs_start();
    xfer({25'd0, 5'h1E, 2'b11}, 7, rx);
    xfer(32'h11, 8, rx);
    xfer(32'h22, 8, rx);
    xfer(32'h33, 8, rx);
    cs_end();
    n_checks++; if (we_cnt - we0 !== exp_n) begin n_fail++; $display("FAIL bwr_we_count: got %0d expected %0d", we_cnt - we0, exp_n); end
    for (int i = 0; i < exp_n; i++) begin
      n_checks++; if (we_addr[(we0 + i) % 64] !== exp_a[i]) begin n_fail++; $display("FAIL bwr_addr[%0d]: got %h expected %h", i, we_addr[(we0 + i) % 64], exp_a[i]); end
      n_checks++; if (we_data[(we0 + i) % 64] !== exp_d[i]) begin n_fail++; $display("FAIL bwr_data[%0d]: got %h expected %h", i, we_data[(we0 + i) % 64], exp_d[i]); end
    end
    n_checks++; if (wrap_cnt - wr0 !== (BURST ? 1 : 0)) begin n_fail++; $display("FAIL bwr_wrap_count: got %0d expected %0d", wrap_cnt - wr0, BURST ? 1 : 0); end
    n_checks++; if (bus.Addr !== (BURST ? 5'h01 : 5'h1E)) begin n_fail++; $display("FAIL bwr_final_addr: got %h expected %h", bus.Addr, BURST ? 5'h01 : 5'h1E); end
  endtask

  task automatic test_burst_read();
    int re0, wr0;
    logic [31:0] rx0, rx1;
    mem[31] = 8'h96;
    mem[0]  = 8'h5B;
    re0 = re_cnt; wr0 = wrap_cnt;
    cs_start();
    xfer({25'd0, 5'h1F, 2'b01}, 7, rx0);
    xfer(32'h0, 1, rx0);
    xfer(32'h0, 8, rx0);
    xfer(32'h0, 1, rx1);
    xfer(32'h0, 8, rx1);
    cs_end();
    n_checks++; if (re_cnt - re0 !== (BURST ? 2 : 1)) begin n_fail++; $display("FAIL brd_re_count: got %0d expected %0d", re_cnt - re0, BURST ? 2 : 1); end
    n_checks++; if (re_addr[re0 % 64] !== 5'h1F) begin n_fail++; $display("FAIL brd_addr0: got %h expected 1f", re_addr[re0 % 64]); end
    n_checks++; if (BURST && re_addr[(re0 + 1) % 64] !== 5'h00) begin n_fail++; $display("FAIL brd_addr1: got %h expected 00", re_addr[(re0 + 1) % 64]); end
    n_checks++; if (rx0[7:0] !== 8'h96) begin n_fail++; $display("FAIL brd_word0: got %h expected 96", rx0[7:0]); end
    n_checks++; if (rx1[7:0] !== (BURST ? 8'h5B : 8'h00)) begin n_fail++; $display("FAIL brd_word1: got %h expected %h", rx1[7:0], BURST ? 8'h5B : 8'h00); end
    n_checks++; if (wrap_cnt - wr0 !== (BURST ? 1 : 0)) begin n_fail++; $display("FAIL brd_wrap_count: got %0d expected %0d", wrap_cnt - wr0, BURST ? 1 : 0); end
  endtask

  task automatic test_abort_write();
    int we0;
    logic [31:0] rx;
    we0 = we_cnt;
    cs_start();
    xfer({25'd0, 5'h07, 2'b10}, 7, rx);
    xfer(32'hF, 4, rx);
    cs_end();
    n_checks++; if (we_cnt - we0 !== 0) begin n_fail++; $display("FAIL abort_we_count: got %0d expected 0", we_cnt - we0); end
    n_checks++; if (bus.Addr !== 5'h07) begin n_fail++; $display("FAIL abort_addr_kept: got %h expected 07", bus.Addr); end
    n_checks++; if (bus.Data_out !== (BURST ? 8'h33 : 8'h11)) begin n_fail++; $display("FAIL abort_data_kept: got %h expected %h", bus.Data_out, BURST ? 8'h33 : 8'h11); end
    we0 = we_cnt;
    cs_start();
    xfer({25'd0, 5'h05, 2'b10}, 7, rx);
    xfer(32'h5A, 8, rx);
    cs_end();
    n_checks++; if (we_cnt - we0 !== 1) begin n_fail++; $display("FAIL after_abort_we_count: got %0d expected 1", we_cnt - we0); end
    n_checks++; if (we_addr[we0 % 64] !== 5'h05) begin n_fail++; $display("FAIL after_abort_addr: got %h expected 05", we_addr[we0 % 64]); end
    n_checks++; if (we_data[we0 % 64] !== 8'h5A) begin n_fail++; $display("FAIL after_abort_data: got %h expected 5a", we_data[we0 % 64]); end
  endtask

  task automatic test_reset_midframe();
    int we0, re0;
    logic [31:0] rx;
    mem[2] = 8'hE7;
    mem[4] = 8'hC3;
    cs_start();
    xfer({25'd0, 5'h02, 2'b01}, 7, rx);
    xfer(32'h0, 1, rx);
    xfer(32'h0, 3, rx);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.MISO !== 1'b0) begin n_fail++; $display("FAIL midrst_miso: got %b expected 0", bus.MISO); end
    n_checks++; if (bus.Addr !== 5'h00) begin n_fail++; $display("FAIL midrst_addr: got %h expected 00", bus.Addr); end
    n_checks++; if (bus.Data_out !== 8'h00) begin n_fail++; $display("FAIL midrst_data_out: got %h expected 00", bus.Data_out); end
    n_checks++; if (bus.WE !== 1'b0) begin n_fail++; $display("FAIL midrst_we: got %b expected 0", bus.WE); end
    n_checks++; if (bus.RE !== 1'b0) begin n_fail++; $display("FAIL midrst_re: got %b expected 0", bus.RE); end
    n_checks++; if (bus.Wrap !== 1'b0) begin n_fail++; $display("FAIL midrst_wrap: got %b expected 0", bus.Wrap); end
    rst = 1'b1;
    we0 = we_cnt; re0 = re_cnt;
    xfer(32'h3FF, 10, rx);
    n_checks++; if (re_cnt - re0 !== 0) begin n_fail++; $display("FAIL postrst_re_count: got %0d expected 0", re_cnt - re0); end
    n_checks++; if (we_cnt - we0 !== 0) begin n_fail++; $display("FAIL postrst_we_count: got %0d expected 0", we_cnt - we0); end
    cs_end();
    re0 = re_cnt;
    cs_start();
    xfer({25'd0, 5'h04, 2'b00}, 7, rx);
    xfer(32'h0, 1, rx);
    xfer(32'h0, 8, rx);
    cs_end();
    n_checks++; if (re_cnt - re0 !== 1) begin n_fail++; $display("FAIL newframe_re_count: got %0d expected 1", re_cnt - re0); end
    n_checks++; if (re_addr[re0 % 64] !== 5'h04) begin n_fail++; $display("FAIL newframe_addr: got %h expected 04", re_addr[re0 % 64]); end
    n_checks++; if (rx[7:0] !== 8'hC3) begin n_fail++; $display("FAIL newframe_word: got %h expected c3", rx[7:0]); end
  endtask

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
    test_reset();
    test_single_write();
    test_single_read();
    test_burst_write();
    test_burst_read();
    test_abort_write();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
